// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I funct3
// codes, and the funct3 legality / alignment decode used at request accept.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction

  // Size is encoded in f3[1:0] for every legal code: 00 byte, 01 half, 10 word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Offset bits below the access size are dropped (LH @0x3 acts on 0x2).
  function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return {off[1], 1'b0};
      2'b10:   return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and sign/zero-extends a byte or half from
// a memory word for loads, and merges store byte/half into a word for RMW.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  input  logic [31:0] i_sdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_mdata
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shamt   = {i_off, 3'b000};
  assign w_shifted = i_word >> w_shamt;
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_ldata = i_word;
    case (i_funct3)
      F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
      F3_BU:   o_ldata = {24'h0, w_byte};
      F3_HU:   o_ldata = {16'h0, w_half};
      default: o_ldata = i_word;
    endcase
  end

  always_comb begin
    o_mdata = i_sdata;
    case (i_funct3)
      F3_B:    o_mdata = (i_word & ~(32'h0000_00FF << w_shamt))
                       | ({24'h0, i_sdata[7:0]} << w_shamt);
      F3_H:    o_mdata = (i_word & ~(32'h0000_FFFF << w_shamt))
                       | ({16'h0, i_sdata[15:0]} << w_shamt);
      default: o_mdata = i_sdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store unit in front of a word-only memory with RMW for SB/SH.
// Build option LSU_MISALIGN_TRAP_EN: misaligned H/W accesses return RSP_ERR.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [31:0] MEM_ADDR,
  output logic        MEM_RW,
  output logic [31:0] MEM_WD,
  input  logic [31:0] MEM_RD
);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_misalign;
  logic        w_err;
  logic [31:0] w_ldata;
  logic [31:0] w_mdata;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(REQ_FUNCT3, REQ_ADDR[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept = REQ_VALID && (r_state == S_IDLE);
  assign w_err    = f3_illegal(REQ_WE, REQ_FUNCT3) || w_misalign;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Handshake and memory strobes decode from state alone, so reset drops them at once.
  always_comb begin
    w_next    = r_state;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    MEM_RW    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          if (w_err)                    w_next = S_RESP;
          else if (!REQ_WE)             w_next = S_LOAD;
          else if (REQ_FUNCT3 == F3_W)  w_next = S_WRITE;
          else                          w_next = S_RMW_RD;
        end
      end
      S_LOAD:   w_next = S_RESP;
      S_RMW_RD: w_next = S_WRITE;
      S_WRITE: begin
        MEM_RW = 1'b1;
        w_next = S_RESP;
      end
      S_RESP: begin
        RSP_VALID = 1'b1;
        w_next    = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_f3    <= 3'b000;
      r_off   <= 2'b00;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_f3    <= REQ_FUNCT3;
      r_off   <= eff_off(REQ_FUNCT3, REQ_ADDR[1:0]);
      r_addr  <= {REQ_ADDR[31:2], 2'b00};
      r_wdata <= REQ_WDATA;
      r_rdata <= 32'h0;
      r_err   <= w_err;
    end else if (r_state == S_LOAD) begin
      r_rdata <= w_ldata;
    end else if (r_state == S_RMW_RD) begin
      r_wdata <= w_mdata;
    end
  end

  lsu_align u_align (
    .i_funct3 (r_f3),
    .i_off    (r_off),
    .i_word   (MEM_RD),
    .i_sdata  (r_wdata),
    .o_ldata  (w_ldata),
    .o_mdata  (w_mdata)
  );

  assign MEM_ADDR  = r_addr;
  assign MEM_WD    = (r_state == S_WRITE) ? r_wdata : 32'h0;
  assign RSP_RDATA = r_rdata;
  assign RSP_ERR   = r_err;

endmodule
